// File: rtl/catgame_pkg.sv
// Shared types and constants for the cat-trap game sequencer: cell codes, FSM
// states, board geometry and the default cat start position.
package catgame_pkg;

  localparam int GRID_N = 8;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_WHITE  = 2'd0;
  localparam cell_t CELL_GRAY   = 2'd1;
  localparam cell_t CELL_ORANGE = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_PLAY,
    ST_CAT_EVAL,
    ST_CAT_MOVE,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [2:0] EDGE_MAX  = 3'(GRID_N - 1);
  localparam logic [2:0] START_ROW = 3'd3;
  localparam logic [2:0] START_COL = 3'd3;

  // A cat standing on the border has escaped.
  function automatic logic on_edge(input logic [2:0] r, input logic [2:0] c);
    return (r == 3'd0) || (r == EDGE_MAX) || (c == 3'd0) || (c == EDGE_MAX);
  endfunction

endpackage

// File: rtl/catgame_if.sv
// Button, display-read and status bundle between the game sequencer (slave)
// and whatever drives the buttons and scans the board (master).
interface catgame_if #(
  parameter int CNT_W = 8
) ();

  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             btn_center;
  logic [2:0]       rd_row;
  logic [2:0]       rd_col;
  logic [1:0]       rd_cell;
  logic [2:0]       cursor_row;
  logic [2:0]       cursor_col;
  logic             game_win;
  logic             game_lose;
  logic             busy;
  logic [CNT_W-1:0] move_count;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_center, rd_row, rd_col,
    input  rd_cell, cursor_row, cursor_col, game_win, game_lose, busy, move_count
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_center, rd_row, rd_col,
    output rd_cell, cursor_row, cursor_col, game_win, game_lose, busy, move_count
  );

endinterface

// File: rtl/catgame_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) supplying the
// random cat start; only used when CATGAME_RANDOM_START_EN is defined.
module catgame_lfsr (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] o_lsb
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb  = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];
  assign o_lsb = r_state[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= 16'hACE1;
    else       r_state <= {r_state[14:0], w_fb};
  end

endmodule

// File: rtl/catgame_sequencer.sv
// Cat-trap game sequencer: 8x8 board, cursor, wall placement and cat AI.
// Optional macro CATGAME_RANDOM_START_EN randomises the cat start cell.
module catgame_sequencer #(
  parameter int GRID_N = catgame_pkg::GRID_N,
  parameter int CNT_W  = 8
) (
  input logic      clk,
  input logic      reset,
  catgame_if.slave bus
);
  import catgame_pkg::*;

  localparam int CELLS = GRID_N * GRID_N;

  state_t           r_state, w_state_nxt;
  cell_t            r_board [GRID_N][GRID_N];
  logic [6:0]       r_idx;
  logic [2:0]       r_cur_row, r_cur_col;
  logic [2:0]       r_cat_row, r_cat_col;
  logic [2:0]       r_tgt_row, r_tgt_col;
  logic [CNT_W-1:0] r_move_count;
  logic [2:0]       w_start_row, w_start_col;
  logic [2:0]       w_rp1, w_rm1, w_cp1, w_cm1;
  logic             w_free_dn, w_free_up, w_free_rt, w_free_lt, w_found;
  logic [2:0]       w_nb_row, w_nb_col;
  logic             w_init_done, w_place;
  logic             w_busy, w_win, w_lose;

`ifdef CATGAME_RANDOM_START_EN
  logic [1:0] w_rand;
  catgame_lfsr u_lfsr (.clk(clk), .reset(reset), .o_lsb(w_rand));
  assign w_start_row = START_ROW + {2'b00, w_rand[1]};
  assign w_start_col = START_COL + {2'b00, w_rand[0]};
`else
  assign w_start_row = START_ROW;
  assign w_start_col = START_COL;
`endif

  assign w_init_done = (r_idx == 7'(CELLS));
  assign w_place     = (r_state == ST_PLAY) && bus.btn_center &&
                       (r_board[r_cur_row][r_cur_col] == CELL_WHITE);

  // Wrapped neighbour indices are harmless: the edge test masks them out.
  assign w_rp1 = r_cat_row + 3'd1;
  assign w_rm1 = r_cat_row - 3'd1;
  assign w_cp1 = r_cat_col + 3'd1;
  assign w_cm1 = r_cat_col - 3'd1;
  assign w_free_dn = (r_cat_row != EDGE_MAX) && (r_board[w_rp1][r_cat_col] == CELL_WHITE);
  assign w_free_up = (r_cat_row != 3'd0)     && (r_board[w_rm1][r_cat_col] == CELL_WHITE);
  assign w_free_rt = (r_cat_col != EDGE_MAX) && (r_board[r_cat_row][w_cp1] == CELL_WHITE);
  assign w_free_lt = (r_cat_col != 3'd0)     && (r_board[r_cat_row][w_cm1] == CELL_WHITE);
  assign w_found   = w_free_dn | w_free_up | w_free_rt | w_free_lt;

  always_comb begin
    w_nb_row = r_cat_row;
    w_nb_col = r_cat_col;
    if (w_free_dn)      w_nb_row = w_rp1;
    else if (w_free_up) w_nb_row = w_rm1;
    else if (w_free_rt) w_nb_col = w_cp1;
    else if (w_free_lt) w_nb_col = w_cm1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:     if (w_init_done) w_state_nxt = ST_PLAY;
      ST_PLAY:     if (w_place) w_state_nxt = ST_CAT_EVAL;
      ST_CAT_EVAL: w_state_nxt = w_found ? ST_CAT_MOVE : ST_WIN;
      ST_CAT_MOVE: w_state_nxt = on_edge(r_tgt_row, r_tgt_col) ? ST_LOSE : ST_PLAY;
      ST_WIN,
      ST_LOSE:     if (bus.btn_center) w_state_nxt = ST_INIT;
      default:     w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_win  = 1'b0;
    w_lose = 1'b0;
    case (r_state)
      ST_INIT, ST_CAT_EVAL, ST_CAT_MOVE: w_busy = 1'b1;
      ST_WIN:  w_win  = 1'b1;
      ST_LOSE: w_lose = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_cur_row    <= '0;
      r_cur_col    <= '0;
      r_cat_row    <= START_ROW;
      r_cat_col    <= START_COL;
      r_tgt_row    <= '0;
      r_tgt_col    <= '0;
      r_move_count <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (w_init_done) begin
            r_idx     <= '0;
            r_cat_row <= w_start_row;
            r_cat_col <= w_start_col;
          end else begin
            r_idx <= r_idx + 7'd1;
          end
        end
        ST_PLAY: begin
          // Center has top priority even when it lands on a non-white cell.
          if (!bus.btn_center) begin
            if (bus.btn_up) begin
              if (r_cur_row != 3'd0) r_cur_row <= r_cur_row - 3'd1;
            end else if (bus.btn_down) begin
              if (r_cur_row != EDGE_MAX) r_cur_row <= r_cur_row + 3'd1;
            end else if (bus.btn_left) begin
              if (r_cur_col != 3'd0) r_cur_col <= r_cur_col - 3'd1;
            end else if (bus.btn_right) begin
              if (r_cur_col != EDGE_MAX) r_cur_col <= r_cur_col + 3'd1;
            end
          end
        end
        ST_CAT_EVAL: begin
          r_tgt_row <= w_nb_row;
          r_tgt_col <= w_nb_col;
        end
        ST_CAT_MOVE: begin
          r_cat_row <= r_tgt_row;
          r_cat_col <= r_tgt_col;
          if (r_move_count != '1) r_move_count <= r_move_count + 1'b1;
        end
        ST_WIN, ST_LOSE: begin
          if (bus.btn_center) begin
            r_cur_row    <= '0;
            r_cur_col    <= '0;
            r_move_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Board storage is uninitialised until INIT sweeps it.
  always_ff @(posedge clk) begin
    case (r_state)
      ST_INIT: begin
        if (w_init_done) r_board[w_start_row][w_start_col] <= CELL_ORANGE;
        else             r_board[r_idx[5:3]][r_idx[2:0]]   <= CELL_WHITE;
      end
      ST_PLAY: if (w_place) r_board[r_cur_row][r_cur_col] <= CELL_GRAY;
      ST_CAT_MOVE: begin
        r_board[r_cat_row][r_cat_col] <= CELL_WHITE;
        r_board[r_tgt_row][r_tgt_col] <= CELL_ORANGE;
      end
      default: ;
    endcase
  end

  assign bus.rd_cell    = r_board[bus.rd_row][bus.rd_col];
  assign bus.cursor_row = r_cur_row;
  assign bus.cursor_col = r_cur_col;
  assign bus.move_count = r_move_count;
  assign bus.busy       = w_busy;
  assign bus.game_win   = w_win;
  assign bus.game_lose  = w_lose;

endmodule
